// File: rtl/maxmin_frame.sv
// Streaming per-frame statistics: max, min, first-occurrence indices and sample count.
// Frames end on FRAME_LEN samples or on in_last; clr aborts silently.
module maxmin_frame #(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 15,
    parameter int SIGNED    = 0,
    parameter int IDX_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_num,
    input  logic              in_last,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W-1:0] out_min,
    output logic [IDX_W-1:0]  out_max_idx,
    output logic [IDX_W-1:0]  out_min_idx,
    output logic [IDX_W-1:0]  out_cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACC  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] run_max_q, run_max_d;
    logic [DATA_W-1:0] run_min_q, run_min_d;
    logic [IDX_W-1:0]  max_idx_q, max_idx_d;
    logic [IDX_W-1:0]  min_idx_q, min_idx_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_max_q, out_max_d;
    logic [DATA_W-1:0] out_min_q, out_min_d;
    logic [IDX_W-1:0]  out_max_idx_q, out_max_idx_d;
    logic [IDX_W-1:0]  out_min_idx_q, out_min_idx_d;
    logic [IDX_W-1:0]  out_cnt_q, out_cnt_d;
    logic              done;

    function automatic logic greater(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (SIGNED != 0) return $signed(a) > $signed(b);
        else             return a > b;
    endfunction

    always_comb begin
        state_d       = state_q;
        run_max_d     = run_max_q;
        run_min_d     = run_min_q;
        max_idx_d     = max_idx_q;
        min_idx_d     = min_idx_q;
        cnt_d         = cnt_q;
        out_valid_d   = 1'b0;
        out_max_d     = out_max_q;
        out_min_d     = out_min_q;
        out_max_idx_d = out_max_idx_q;
        out_min_idx_d = out_min_idx_q;
        out_cnt_d     = out_cnt_q;
        done          = 1'b0;

        if (clr) begin
            state_d = ST_IDLE;
        end else if (in_valid) begin
            if (state_q == ST_IDLE) begin
                run_max_d = in_num;
                run_min_d = in_num;
                max_idx_d = '0;
                min_idx_d = '0;
                cnt_d     = IDX_W'(1);
                done      = in_last || (FRAME_LEN == 1);
                state_d   = ST_ACC;
            end else begin
                // Strict compares so ties keep the earlier index.
                if (greater(in_num, run_max_q)) begin
                    run_max_d = in_num;
                    max_idx_d = cnt_q;
                end
                if (greater(run_min_q, in_num)) begin
                    run_min_d = in_num;
                    min_idx_d = cnt_q;
                end
                cnt_d = cnt_q + IDX_W'(1);
                done  = in_last || (cnt_q == IDX_W'(FRAME_LEN - 1));
            end

            if (done) begin
                state_d       = ST_IDLE;
                out_valid_d   = 1'b1;
                out_max_d     = run_max_d;
                out_min_d     = run_min_d;
                out_max_idx_d = max_idx_d;
                out_min_idx_d = min_idx_d;
                out_cnt_d     = cnt_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            run_max_q     <= '0;
            run_min_q     <= '0;
            max_idx_q     <= '0;
            min_idx_q     <= '0;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            out_max_q     <= '0;
            out_min_q     <= '0;
            out_max_idx_q <= '0;
            out_min_idx_q <= '0;
            out_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            run_max_q     <= run_max_d;
            run_min_q     <= run_min_d;
            max_idx_q     <= max_idx_d;
            min_idx_q     <= min_idx_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            out_max_q     <= out_max_d;
            out_min_q     <= out_min_d;
            out_max_idx_q <= out_max_idx_d;
            out_min_idx_q <= out_min_idx_d;
            out_cnt_q     <= out_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_max     = out_max_q;
    assign out_min     = out_min_q;
    assign out_max_idx = out_max_idx_q;
    assign out_min_idx = out_min_idx_q;
    assign out_cnt     = out_cnt_q;

endmodule

// File: tb/tb_maxmin_frame.sv
// Scoreboard bench for maxmin_frame: an unsigned and a signed instance share stimulus;
// expected results are queued at issue time and popped by per-instance monitors.
module tb_maxmin_frame;

    typedef struct packed {
        logic [7:0]  mx;
        logic [7:0]  mn;
        logic [3:0]  mxi;
        logic [3:0]  mni;
        logic [3:0]  cnt;
        logic [31:0] due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, clr, in_valid, in_last, s_en;
    logic [7:0] in_num;
    logic       s_valid;

    logic       u_ov, s_ov;
    logic [7:0] u_max, u_min, s_max, s_min;
    logic [3:0] u_maxi, u_mini, u_cnt, s_maxi, s_mini, s_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] cyc      = 0;
    exp_t        q_u[$];
    exp_t        q_s[$];
    exp_t        eu, es;

    localparam logic [7:0] FA [15] = '{8'd3, 8'd9, 8'd200, 8'd0, 8'd5, 8'd6, 8'd7, 8'd8,
                                       8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15};

    assign s_valid = in_valid & s_en;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    maxmin_frame #(.DATA_W(8), .FRAME_LEN(15), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_num(in_num),
        .in_last(in_last), .out_valid(u_ov), .out_max(u_max), .out_min(u_min),
        .out_max_idx(u_maxi), .out_min_idx(u_mini), .out_cnt(u_cnt));

    maxmin_frame #(.DATA_W(8), .FRAME_LEN(15), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(s_valid), .in_num(in_num),
        .in_last(in_last), .out_valid(s_ov), .out_max(s_max), .out_min(s_min),
        .out_max_idx(s_maxi), .out_min_idx(s_mini), .out_cnt(s_cnt));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] mx, input logic [7:0] mn,
                                input logic [3:0] mxi, input logic [3:0] mni,
                                input logic [3:0] cnt);
        exp_t e;
        e.mx = mx; e.mn = mn; e.mxi = mxi; e.mni = mni; e.cnt = cnt; e.due = 0;
        return e;
    endfunction

    // Called just before driving the completing sample; result is due next cycle.
    task automatic push_u(input exp_t e);
        e.due = cyc + 1;
        q_u.push_back(e);
    endtask

    task automatic push_s(input exp_t e);
        e.due = cyc + 1;
        q_s.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [7:0] n, input logic l, input logic c);
        in_valid = v; in_num = n; in_last = l; clr = c;
        @(posedge clk); #1;
        $display("cyc %0d: in_valid=%0b in_num=%0d in_last=%0b clr=%0b", cyc, v, n, l, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'hFF, 1'b1, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, u_ov}, 0);
        chk({tag, "_max"},   {24'd0, u_max}, 0);
        chk({tag, "_min"},   {24'd0, u_min}, 0);
        chk({tag, "_maxi"},  {28'd0, u_maxi}, 0);
        chk({tag, "_mini"},  {28'd0, u_mini}, 0);
        chk({tag, "_cnt"},   {28'd0, u_cnt}, 0);
        chk({tag, "_s_valid"}, {31'd0, s_ov}, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && u_ov) begin
            if (q_u.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_out_valid_u: got pulse at cyc %0d expected none", cyc);
            end else begin
                eu = q_u.pop_front();
                $display("cyc %0d: u result max=%0d@%0d min=%0d@%0d cnt=%0d", cyc, u_max, u_maxi, u_min, u_mini, u_cnt);
                chk("u_latency", cyc, eu.due);
                chk("u_max", {24'd0, u_max}, {24'd0, eu.mx});
                chk("u_min", {24'd0, u_min}, {24'd0, eu.mn});
                chk("u_max_idx", {28'd0, u_maxi}, {28'd0, eu.mxi});
                chk("u_min_idx", {28'd0, u_mini}, {28'd0, eu.mni});
                chk("u_cnt", {28'd0, u_cnt}, {28'd0, eu.cnt});
            end
        end
        if (!rst && s_ov) begin
            if (q_s.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_out_valid_s: got pulse at cyc %0d expected none", cyc);
            end else begin
                es = q_s.pop_front();
                $display("cyc %0d: s result max=%0d@%0d min=%0d@%0d cnt=%0d", cyc, s_max, s_maxi, s_min, s_mini, s_cnt);
                chk("s_latency", cyc, es.due);
                chk("s_max", {24'd0, s_max}, {24'd0, es.mx});
                chk("s_min", {24'd0, s_min}, {24'd0, es.mn});
                chk("s_max_idx", {28'd0, s_maxi}, {28'd0, es.mxi});
                chk("s_min_idx", {28'd0, s_mini}, {28'd0, es.mni});
                chk("s_cnt", {28'd0, s_cnt}, {28'd0, es.cnt});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_num = 8'd0; s_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        idle(1);

        // Full unsigned frame
        for (int i = 0; i < 15; i++) begin
            if (i == 14) push_u(mk(8'd200, 8'd0, 4'd2, 4'd3, 4'd15));
            drive(1'b1, FA[i], 1'b0, 1'b0);
        end
        idle(2);

        // Same data through both instances: signed vs unsigned ordering
        s_en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i == 14) begin
                push_u(mk(8'h80, 8'h00, 4'd5, 4'd1, 4'd15));
                push_s(mk(8'h7F, 8'h80, 4'd0, 4'd5, 4'd15));
            end
            drive(1'b1, (i == 0) ? 8'h7F : (i == 5) ? 8'h80 : 8'h00, 1'b0, 1'b0);
        end
        s_en = 1'b0;
        idle(2);

        // Early end with a tie on the max
        drive(1'b1, 8'd10, 1'b0, 1'b0);
        drive(1'b1, 8'd20, 1'b0, 1'b0);
        drive(1'b1, 8'd20, 1'b0, 1'b0);
        push_u(mk(8'd20, 8'd5, 4'd1, 4'd3, 4'd4));
        drive(1'b1, 8'd5, 1'b1, 1'b0);
        idle(2);

        // Gaps after samples 4 and 9; in_last/in_num during gaps must be ignored
        for (int i = 0; i < 15; i++) begin
            if (i == 14) push_u(mk(8'd200, 8'd0, 4'd2, 4'd3, 4'd15));
            drive(1'b1, FA[i], 1'b0, 1'b0);
            if (i == 3 || i == 8) idle(3);
        end
        idle(2);

        // Abort after 7 samples, clr coinciding with a sample
        for (int i = 0; i < 7; i++) drive(1'b1, (i == 0) ? 8'd255 : 8'd1, 1'b0, 1'b0);
        drive(1'b1, 8'd250, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) begin
            if (i == 14) push_u(mk(8'd114, 8'd100, 4'd14, 4'd0, 4'd15));
            drive(1'b1, 8'(100 + i), (i == 14), 1'b0);
        end
        idle(1);
        // clr with a sample while idle: sample must not seed a frame
        drive(1'b1, 8'd1, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) begin
            if (i == 14) push_u(mk(8'd114, 8'd100, 4'd14, 4'd0, 4'd15));
            drive(1'b1, 8'(100 + i), 1'b0, 1'b0);
        end

        // Back-to-back completions with no bubble
        drive(1'b1, 8'd7, 1'b0, 1'b0);
        push_u(mk(8'd7, 8'd3, 4'd0, 4'd1, 4'd2));
        drive(1'b1, 8'd3, 1'b1, 1'b0);
        push_u(mk(8'd42, 8'd42, 4'd0, 4'd0, 4'd1));
        drive(1'b1, 8'd42, 1'b1, 1'b0);
        push_u(mk(8'd17, 8'd17, 4'd0, 4'd0, 4'd1));
        drive(1'b1, 8'd17, 1'b1, 1'b0);
        drive(1'b1, 8'd1, 1'b0, 1'b0);
        drive(1'b1, 8'd2, 1'b0, 1'b0);

        // Asynchronous reset mid-frame
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
        for (int i = 0; i < 15; i++) begin
            if (i == 14) push_u(mk(8'd200, 8'd0, 4'd2, 4'd3, 4'd15));
            drive(1'b1, FA[i], 1'b0, 1'b0);
        end
        idle(4);

        chk("pending_u", q_u.size(), 0);
        chk("pending_s", q_s.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
